jtroadf_snd_if: RTL

Sound-board end of the main-to-sound command path. It captures the byte the main CPU writes to the sound latch and turns rising edges of the main CPU's snd_irq line into a Z80 interrupt held until acknowledged. It also provides the free-running timer byte read through AY-1 port B, and decodes the sound Z80 memory map into chip selects. It sits between the main CPU block and the sound CPU/AY PSG instances in the game top level.

---
 rtl/jtroadf_snd_if_if.sv | 27 ++
 rtl/jtroadf_snd_if.sv | 81 ++++++++
 2 files changed

// File: rtl/jtroadf_snd_if_if.sv
// Sound Z80 bus as seen by the sound interface block.
// The CPU side drives the address and control lines; the block returns the interrupt and chip selects.
interface jtroadf_snd_if_if;
   logic [15:0] A;
   logic        cen;
   logic        mreq_n;
   logic        iorq_n;
   logic        m1_n;
   logic        rd_n;
   logic        wr_n;
   logic        int_n;
   logic        rom_cs;
   logic        ram_cs;
   logic        ay1_cs;
   logic        ay2_cs;
   logic        ay_bdir_addr;

   modport master (
      output A, cen, mreq_n, iorq_n, m1_n, rd_n, wr_n,
      input  int_n, rom_cs, ram_cs, ay1_cs, ay2_cs, ay_bdir_addr
   );

   modport slave (
      input  A, cen, mreq_n, iorq_n, m1_n, rd_n, wr_n,
      output int_n, rom_cs, ram_cs, ay1_cs, ay2_cs, ay_bdir_addr
   );
endinterface

// File: rtl/jtroadf_snd_if.sv
// Main-to-sound command latch, edge-triggered Z80 interrupt, AY port-B timer
// and sound Z80 memory decode.
module jtroadf_snd_if #(
   parameter int TMR_DIV = 512,
   parameter int TMR_W   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  main_cen,
   input  logic                  main_rnw,
   input  logic                  snd_data_cs,
   input  logic [7:0]            main_dout,
   input  logic                  snd_irq,
   jtroadf_snd_if_if.slave       z80,
   output logic [7:0]            latch_dout,
   output logic [7:0]            timer_dout,
   output logic                  ovr
);
   localparam int PW = (TMR_DIV > 1) ? $clog2(TMR_DIV) : 1;

   logic [7:0]       latch_q, latch_d;
   logic             pend_q, pend_d;
   logic             irq_q;
   logic             ovr_q, ovr_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;

   logic latch_we, rise, ack, pre_wrap;

   assign latch_we = main_cen & snd_data_cs & ~main_rnw;
   assign rise     = snd_irq & ~irq_q;
   assign ack      = z80.cen & ~z80.m1_n & ~z80.iorq_n;
   assign pre_wrap = pre_q == PW'(TMR_DIV - 1);

   always_comb begin
      latch_d = latch_we ? main_dout : latch_q;
      // an unacknowledged command being overwritten is recorded for good
      ovr_d   = ovr_q | (latch_we & pend_q);
      // a new rising edge beats an acknowledge arriving on the same clock
      pend_d  = rise ? 1'b1 : (ack ? 1'b0 : pend_q);
      pre_d   = pre_q;
      tmr_d   = tmr_q;
      if (z80.cen) begin
         pre_d = pre_wrap ? '0 : pre_q + 1'b1;
         if (pre_wrap) tmr_d = tmr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // loading the live level during reset stops a held-high line firing afterwards
      irq_q <= snd_irq;
      if (rst) begin
         latch_q <= '0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
         pre_q   <= '0;
         tmr_q   <= '0;
      end else begin
         latch_q <= latch_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         pre_q   <= pre_d;
         tmr_q   <= tmr_d;
      end
   end

   assign z80.int_n  = ~pend_q;
   assign latch_dout = latch_q;
   assign ovr        = ovr_q;
   assign timer_dout = 8'(tmr_q) << (8 - TMR_W);

   // decode ignores rd_n/wr_n; the AY instances sort out direction themselves
   assign z80.rom_cs       = ~z80.mreq_n & (z80.A[15:13] == 3'b000);
   assign z80.ram_cs       = ~z80.mreq_n & (z80.A[15:10] == 6'b001100);
   assign z80.ay1_cs       = ~z80.mreq_n & (z80.A[15:13] == 3'b010);
   assign z80.ay2_cs       = ~z80.mreq_n & (z80.A[15:13] == 3'b011);
   assign z80.ay_bdir_addr = z80.A[12];

   logic unused_ok;
   assign unused_ok = &{1'b0, z80.rd_n, z80.wr_n, z80.A[11:0]};
endmodule
